// File: rtl/uvc_frame_fifo.sv
// Byte FIFO between a video producer and the UVC packetiser, aligned to frame starts.
// Optional overflow/underflow event counters are enabled with `define UVC_FRAME_FIFO_STATS_EN.
module uvc_frame_fifo #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned FRAME_BYTES = 230400,
    parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
    input  logic                  clk,
    input  logic                  usb_rstn,
    input  logic                  pix_sof,
    input  logic                  pix_valid,
    input  logic [7:0]            pix_data,
    output logic                  pix_ready,
    input  logic                  vf_sof,
    input  logic                  vf_req,
    output logic [7:0]            vf_byte,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           udf_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_base, wr_nxt, rd_nxt;
    logic [31:0]   byte_cnt, cnt_base, cnt_nxt;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    head_nxt;
    logic          full, empty, push, pop, ovf_evt, udf_evt;

    assign level     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pix_ready = ~full;

    // vf_sof flushes first; a byte carrying pix_sof in the same cycle becomes byte 0.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        ovf_evt   = 1'b0;
        cnt_base  = byte_cnt;
        wr_base   = wr_ptr;
        if (vf_sof) begin
            cnt_base  = '0;
            wr_base   = '0;
            state_nxt = ST_ARMED;
            push      = pix_valid && pix_sof;
        end else begin
            case (state)
                ST_ARMED:  push = pix_valid && pix_sof && !full;
                ST_STREAM: begin
                    push    = pix_valid && !full;
                    ovf_evt = pix_valid && full;
                end
                default: ;
            endcase
        end
        cnt_nxt = cnt_base + 32'(push);
        if (push)
            state_nxt = (cnt_nxt == 32'(FRAME_BYTES)) ? ST_IDLE : ST_STREAM;
        wr_nxt = wr_base + PW'(push);
    end

    assign pop     = vf_req && !empty && !vf_sof;
    assign udf_evt = vf_req && empty && !vf_sof;
    assign rd_nxt  = vf_sof ? '0 : (rd_ptr + PW'(pop));

    // Head register tracks the next cycle's oldest byte, bypassing a same-cycle write.
    always_comb begin
        if (wr_nxt == rd_nxt)
            head_nxt = FILL_BYTE;
        else if (push && (rd_nxt == wr_base))
            head_nxt = pix_data;
        else
            head_nxt = mem[rd_nxt[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_base[DEPTH_LOG2-1:0]] <= pix_data;
    end

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            byte_cnt  <= '0;
            vf_byte   <= FILL_BYTE;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            byte_cnt <= cnt_nxt;
            vf_byte  <= head_nxt;
            if (vf_sof) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (ovf_evt) overflow  <= 1'b1;
                if (udf_evt) underflow <= 1'b1;
            end
        end
    end

`ifdef UVC_FRAME_FIFO_STATS_EN
    logic [15:0] ovf_q, udf_q;

    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            if (ovf_evt && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            if (udf_evt && udf_q != 16'hFFFF) udf_q <= udf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;
`else
    assign ovf_cnt = '0;
    assign udf_cnt = '0;
`endif

endmodule

// File: tb/tb_uvc_frame_fifo.sv
// Scoreboard bench for uvc_frame_fifo: DEPTH_LOG2=2, FRAME_BYTES=12, FILL_BYTE=8'hE7.
// Counter expectations follow UVC_FRAME_FIFO_STATS_EN as defined for the build.
module tb_uvc_frame_fifo;

    localparam int unsigned DL   = 2;
    localparam int unsigned FB   = 12;
    localparam logic [7:0]  FILL = 8'hE7;
`ifdef UVC_FRAME_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          usb_rstn;
    logic          pix_sof, pix_valid, vf_sof, vf_req;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic [7:0]    vf_byte;
    logic [DL:0]   level;
    logic          overflow, underflow;
    logic [15:0]   ovf_cnt, udf_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    uvc_frame_fifo #(.DEPTH_LOG2(DL), .FRAME_BYTES(FB), .FILL_BYTE(FILL)) u_dut (
        .clk(clk), .usb_rstn(usb_rstn), .pix_sof(pix_sof), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .vf_sof(vf_sof), .vf_req(vf_req),
        .vf_byte(vf_byte), .level(level), .overflow(overflow), .underflow(underflow),
        .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    // Drive one cycle; the popped byte is checked before the write is queued.
    task automatic step(input logic s_vf, input logic pv, input logic ps,
                        input logic [7:0] pd, input logic rq, input bit acc);
        logic [7:0] exp;
        vf_sof = s_vf; pix_valid = pv; pix_sof = ps; pix_data = pd; vf_req = rq;
        if (s_vf) exp_q.delete();
        if (rq) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : FILL;
            check_eq("vf_byte", 32'(vf_byte), 32'(exp));
        end
        if (acc) exp_q.push_back(pd);
        @(posedge clk); #1;
        vf_sof = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00; vf_req = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_gap();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        usb_rstn = 1'b0;
        vf_sof = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00; vf_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_vf_byte", 32'(vf_byte), 32'(FILL));
        check_eq("rst_pix_ready", 32'(pix_ready), 1);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_underflow", 32'(underflow), 0);
        check_eq("rst_ovf_cnt", 32'(ovf_cnt), 0);
        check_eq("rst_udf_cnt", 32'(udf_cnt), 0);
        usb_rstn = 1'b1;
        idle();

        // basic frame: IDLE and ARMED discard, then three bytes in order
        step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        check_eq("idle_discard_level", 32'(level), 0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
        check_eq("armed_discard_level", 32'(level), 0);
        step(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1);
        check_eq("basic_level3", 32'(level), 3);
        for (int i = 2; i >= 0; i--) begin
            pop_gap();
            check_eq("basic_level_drain", 32'(level), 32'(i));
        end

        // underflow on empty pops
        pop_gap();
        check_eq("udf_flag", 32'(underflow), 1);
        check_eq("udf_level", 32'(level), 0);
        check_eq("udf_cnt1", 32'(udf_cnt), stat(1));
        pop_gap();
        check_eq("udf_cnt2", 32'(udf_cnt), stat(2));

        // overflow with a 4-deep FIFO
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("sof_clears_udf", 32'(underflow), 0);
        check_eq("udf_cnt_kept", 32'(udf_cnt), stat(2));
        step(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1);
        for (int i = 1; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b1);
        check_eq("full_pix_ready", 32'(pix_ready), 0);
        check_eq("full_level", 32'(level), 4);
        step(1'b0, 1'b1, 1'b0, 8'h24, 1'b0, 1'b0);
        check_eq("ovf_flag", 32'(overflow), 1);
        check_eq("ovf_level", 32'(level), 4);
        check_eq("ovf_cnt1", 32'(ovf_cnt), stat(1));
        repeat (4) pop_gap();
        check_eq("ovf_drained_level", 32'(level), 0);
        check_eq("ovf_drained_ready", 32'(pix_ready), 1);

        // resync mid-STREAM with three bytes buffered
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b1);
        check_eq("resync_pre_level", 32'(level), 3);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("resync_level", 32'(level), 0);
        check_eq("resync_ovf", 32'(overflow), 0);
        check_eq("resync_udf", 32'(underflow), 0);
        check_eq("resync_ovf_cnt", 32'(ovf_cnt), stat(1));
        step(1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0);
        check_eq("resync_armed_level", 32'(level), 0);
        step(1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1);
        check_eq("resync_first_level", 32'(level), 1);
        pop_gap();

        // vf_sof and pix_sof in the same cycle
        step(1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
        check_eq("sof_pair_level", 32'(level), 1);
        pop_gap();

        // push into empty with a pop, then interleaved pairs to frame end (pointer wrap)
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h60, 1'b1, 1'b1);
        check_eq("push_pop_empty_udf", 32'(underflow), 1);
        check_eq("push_pop_empty_level", 32'(level), 1);
        check_eq("udf_cnt3", 32'(udf_cnt), stat(3));
        for (int i = 1; i < FB; i++) begin
            idle();
            step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b1, 1'b1);
            check_eq("wrap_level", 32'(level), 1);
        end
        idle();
        pop_gap();
        check_eq("frame_end_level", 32'(level), 0);
        step(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h98, 1'b0, 1'b0);
        check_eq("after_frame_level", 32'(level), 0);
        check_eq("after_frame_ready", 32'(pix_ready), 1);

        // asynchronous reset mid-frame
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h70, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h71, 1'b0, 1'b0);
        check_eq("pre_reset_level", 32'(level), 2);
        usb_rstn = 1'b0;
        #1;
        check_eq("async_rst_level", 32'(level), 0);
        check_eq("async_rst_vf_byte", 32'(vf_byte), 32'(FILL));
        check_eq("async_rst_ready", 32'(pix_ready), 1);
        check_eq("async_rst_ovf_cnt", 32'(ovf_cnt), 0);
        check_eq("async_rst_udf_cnt", 32'(udf_cnt), 0);
        @(posedge clk); #1;
        usb_rstn = 1'b1;
        exp_q.delete();
        step(1'b0, 1'b1, 1'b1, 8'h72, 1'b0, 1'b0);
        check_eq("post_rst_idle_level", 32'(level), 0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h73, 1'b0, 1'b1);
        check_eq("post_rst_level", 32'(level), 1);
        pop_gap();
        check_eq("final_level", 32'(level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uvc_frame_fifo.md
UVC_FRAME_FIFO -- requirements
Module: uvc_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning FIFO depth = 2^DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter FRAME_BYTES, default 230400, meaning bytes per video frame written (32-bit).
REQ-003 SHALL have parameter FILL_BYTE, default 8'h00, meaning byte returned on underflow.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 usb_rstn  input  1  reset, asynchronous, active-low.
REQ-006 pix_sof  input  1  first byte of a producer frame, qualified by pix_valid.
REQ-007 pix_valid  input  1  producer byte valid.
REQ-008 pix_data  input  8  producer byte.
REQ-009 pix_ready  output  1  FIFO can accept a byte (not full).
REQ-010 vf_sof  input  1  consumer start-of-video-frame pulse from the UVC packetiser.
REQ-011 vf_req  input  1  consumer pop request, single-cycle pulses at least 2 cycles apart.
REQ-012 vf_byte  output  8  byte served to the packetiser.
REQ-013 level  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 underflow  output  1  sticky: vf_req occurred while the FIFO was empty.
REQ-016 ovf_cnt  output  16  overflow event count.
REQ-017 udf_cnt  output  16  underflow event count.

Function
REQ-018 Write FSM SHALL have states IDLE, ARMED, STREAM; IDLE discards all producer bytes.
REQ-019 IDLE -> ARMED on vf_sof; FIFO, level and write byte counter SHALL be flushed to 0 in the same cycle.
REQ-020 ARMED -> STREAM on pix_valid & pix_sof; that byte SHALL be written; bytes without pix_sof in ARMED SHALL be discarded.
REQ-021 STREAM SHALL write each pix_valid byte when not full and increment the 32-bit write byte counter.
REQ-022 STREAM -> IDLE when the counter reaches FRAME_BYTES (after the FRAME_BYTES-th accepted byte).
REQ-023 vf_sof in ARMED or STREAM SHALL flush the FIFO and counter and go to ARMED (resync).
REQ-024 vf_sof and pix_valid & pix_sof in the same cycle: flush, write that byte as byte 0, go to STREAM (counter = 1).
REQ-025 pix_ready SHALL equal ~full in all states; pix_valid while full in STREAM SHALL drop the byte, set overflow, and not advance the counter.
REQ-026 vf_byte SHALL equal the FIFO head byte in every cycle where vf_req=1 and level>0 (show-ahead, registered head).
REQ-027 vf_req with level>0 SHALL pop one byte; the next head SHALL appear on vf_byte by the following cycle.
REQ-028 vf_req with level=0 SHALL present FILL_BYTE on vf_byte, set underflow, and leave pointers unchanged.
REQ-029 Simultaneous push and pop SHALL leave level unchanged; push to empty and pop in same cycle is not a pop (underflow rule applies).
REQ-030 Pointers SHALL be DEPTH_LOG2+1 bits, wrapping modulo 2^(DEPTH_LOG2+1); full when MSBs differ and low bits equal.
REQ-031 overflow/underflow SHALL clear only on reset or on vf_sof flush.

Reset
REQ-032 usb_rstn=0 SHALL asynchronously force state IDLE, pointers 0, level 0, counter 0, vf_byte FILL_BYTE, pix_ready 1, overflow 0, underflow 0, ovf_cnt 0, udf_cnt 0.
REQ-033 Reset asserted mid-frame SHALL discard all buffered bytes; after release, no write occurs until vf_sof then pix_sof.

Configuration
REQ-034 With macro UVC_FRAME_FIFO_STATS_EN defined, ovf_cnt/udf_cnt SHALL increment once per overflow/underflow event, saturating at 16'hFFFF, cleared only by reset.
REQ-035 Without UVC_FRAME_FIFO_STATS_EN, ovf_cnt and udf_cnt SHALL be constant 0 and counters SHALL not be synthesised.

Verification
REQ-036 Reset, vf_sof, then pix_sof+bytes 0x10,0x11,0x12 -> vf_req x3 returns 0x10,0x11,0x12; level 3->0.
REQ-037 vf_req with empty FIFO -> vf_byte=FILL_BYTE (0x00), underflow=1, udf_cnt=1 (macro on) / 0 (macro off).
REQ-038 DEPTH_LOG2=2, write 5 bytes without pops -> pix_ready=0 after 4, 5th dropped, overflow=1, level=4.
REQ-039 FRAME_BYTES=4, producer sends 6 bytes after pix_sof -> only 4 written, state IDLE, further bytes ignored.
REQ-040 vf_sof mid-STREAM with level=3 -> level=0, flags cleared, state ARMED; next pix_sof byte served first.
REQ-041 Pointer wrap: DEPTH_LOG2=2, 10 interleaved push/pop pairs -> bytes returned in order, level never exceeds 2.
